// File: rtl/cpu_pkg.sv
// Shared types and constants for the stack-machine control sequencer.
// Holds the state encoding, opcode map, mux selects and per-state decode.
package cpu_pkg;

   typedef enum logic [3:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_PUSH_IMM,
      S_POP_A,
      S_POP_B,
      S_PUSH_RES,
      S_JUMP,
      S_HALT,
      S_ERROR
   } state_e;

   localparam logic [5:0] OP_NOP    = 6'h00;
   localparam logic [5:0] OP_PUSHI  = 6'h01;
   localparam logic [5:0] OP_ALU_LO = 6'h08;
   localparam logic [5:0] OP_ALU_HI = 6'h0E;
   localparam logic [5:0] OP_JMP    = 6'h10;
   localparam logic [5:0] OP_HALT   = 6'h3F;

   localparam logic [1:0] INC_ALU   = 2'd0;
   localparam logic [1:0] INC_STEP  = 2'd1;
   localparam logic [1:0] INC_START = 2'd2;
   localparam logic [1:0] INC_ZERO  = 2'd3;

   localparam logic [1:0] ADDR_SR    = 2'd0;
   localparam logic [1:0] ADDR_SR_ID = 2'd1;
   localparam logic [1:0] ADDR_PC_ID = 2'd2;
   localparam logic [1:0] ADDR_R1    = 2'd3;

   localparam logic [1:0] DATA_SR  = 2'd0;
   localparam logic [1:0] DATA_PC  = 2'd1;
   localparam logic [1:0] DATA_ALU = 2'd2;
   localparam logic [1:0] DATA_IN  = 2'd3;

   localparam logic [2:0] ALU_PASS = 3'b111;

   localparam logic [15:0] STACK_START_POINT = 16'hFFFF;
   localparam logic [15:0] ENTRY_POINT       = 16'h0020;

   typedef struct packed {
      logic nop;
      logic pushi;
      logic alu;
      logic jmp;
      logic halt;
      logic illegal;
   } op_class_t;

   typedef struct packed {
      logic       cmd_w;
      logic       r1_w;
      logic       r2_w;
      logic       sr_w;
      logic       pc_w;
      logic       sr_inc;
      logic       pc_inc;
      logic [1:0] sr_incc;
      logic [1:0] pc_incc;
      logic [2:0] alu_func;
      logic [1:0] addr_sel;
      logic [1:0] data_sel;
      logic       write_memory;
      logic       error;
      logic       halted;
   } ctl_t;

   // Moore output pattern for a state; func is the opcode's low bits.
   function automatic ctl_t state_ctl(state_e s, logic [2:0] func);
      ctl_t c;
      c = '0;
      unique case (s)
         S_INIT: begin
            c.sr_w    = 1'b1;
            c.pc_w    = 1'b1;
            c.sr_incc = INC_START;
            c.pc_incc = INC_START;
         end
         S_FETCH: begin
            c.addr_sel = ADDR_PC_ID;
            c.pc_inc   = 1'b1;
            c.cmd_w    = 1'b1;
            c.pc_w     = 1'b1;
            c.pc_incc  = INC_STEP;
         end
         S_PUSH_IMM: begin
            c.addr_sel     = ADDR_SR;
            c.data_sel     = DATA_IN;
            c.write_memory = 1'b1;
            c.sr_w         = 1'b1;
            c.sr_incc      = INC_STEP;
         end
         S_POP_A: begin
            c.addr_sel = ADDR_SR_ID;
            c.sr_inc   = 1'b1;
            c.r1_w     = 1'b1;
            c.sr_w     = 1'b1;
            c.sr_incc  = INC_STEP;
         end
         S_POP_B: begin
            c.addr_sel = ADDR_SR_ID;
            c.sr_inc   = 1'b1;
            c.r2_w     = 1'b1;
            c.sr_w     = 1'b1;
            c.sr_incc  = INC_STEP;
         end
         S_PUSH_RES: begin
            c.alu_func     = func;
            c.addr_sel     = ADDR_SR;
            c.data_sel     = DATA_ALU;
            c.write_memory = 1'b1;
            c.sr_w         = 1'b1;
            c.sr_incc      = INC_STEP;
         end
         S_JUMP: begin
            c.alu_func = ALU_PASS;
            c.pc_w     = 1'b1;
            c.pc_incc  = INC_ALU;
         end
         S_HALT:  c.halted = 1'b1;
         S_ERROR: c.error  = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bus between the sequencer and the stack-machine datapath.
// master = sequencer side, slave = datapath side.
interface cpu_sequencer_if;

   logic [5:0] opcode;
   logic       stack_empty;
   logic       cmd_w;
   logic       R1_w;
   logic       R2_w;
   logic       SR_w;
   logic       PC_w;
   logic       SR_inc;
   logic       PC_inc;
   logic [1:0] SR_incc;
   logic [1:0] PC_incc;
   logic [2:0] alu_func;
   logic [1:0] addr_sel;
   logic [1:0] data_sel;
   logic       write_memory;
   logic       error;
   logic       halted;

   modport master (
      input  opcode, stack_empty,
      output cmd_w, R1_w, R2_w, SR_w, PC_w,
      output SR_inc, PC_inc, SR_incc, PC_incc,
      output alu_func, addr_sel, data_sel,
      output write_memory, error, halted
   );

   modport slave (
      output opcode, stack_empty,
      input  cmd_w, R1_w, R2_w, SR_w, PC_w,
      input  SR_inc, PC_inc, SR_incc, PC_incc,
      input  alu_func, addr_sel, data_sel,
      input  write_memory, error, halted
   );

endinterface

// File: rtl/cpu_decode.sv
// Combinational opcode classifier for the sequencer's dispatch.
// Exactly one class bit is set for any opcode.
module cpu_decode
   import cpu_pkg::*;
(
   input  logic [5:0] opcode,
   output op_class_t  cls
);

   always_comb begin
      cls = '0;
      unique case (1'b1)
         opcode == OP_NOP:   cls.nop   = 1'b1;
         opcode == OP_PUSHI: cls.pushi = 1'b1;
         opcode >= OP_ALU_LO && opcode <= OP_ALU_HI:
            cls.alu = 1'b1;
         opcode == OP_JMP:   cls.jmp   = 1'b1;
         opcode == OP_HALT:  cls.halt  = 1'b1;
         default:            cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Control FSM for a 16-bit stack machine: fetch, decode, push/pop and
// jump sequencing with registered Moore outputs and sticky halt/error.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter bit ERR_ON_UNDERFLOW = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   cpu_sequencer_if.master bus
);

   state_e    state_q, state_d;
   ctl_t      ctl_q, ctl_d, ctl;
   logic      init_pend_q, init_pend_d;
   op_class_t cls;
   logic      uflow;

   cpu_decode u_decode (
      .opcode (bus.opcode),
      .cls    (cls)
   );

   assign uflow = ERR_ON_UNDERFLOW && bus.stack_empty &&
                  (state_q == S_POP_A || state_q == S_POP_B);

   // INIT holds one extra cycle after reset so its loads are presented.
   always_comb begin
      state_d     = state_q;
      init_pend_d = 1'b0;
      unique case (state_q)
         S_INIT:     state_d = init_pend_q ? S_INIT : S_FETCH;
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               cls.nop:          state_d = S_FETCH;
               cls.pushi:        state_d = S_PUSH_IMM;
               cls.alu, cls.jmp: state_d = S_POP_A;
               cls.halt:         state_d = S_HALT;
               cls.illegal:      state_d = S_ERROR;
               default:          state_d = S_ERROR;
            endcase
         end
         S_PUSH_IMM: state_d = S_FETCH;
         S_POP_A: begin
            if (uflow)        state_d = S_ERROR;
            else if (cls.jmp) state_d = S_JUMP;
            else              state_d = S_POP_B;
         end
         S_POP_B:    state_d = uflow ? S_ERROR : S_PUSH_RES;
         S_PUSH_RES: state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         S_ERROR:    state_d = S_ERROR;
         default:    state_d = S_ERROR;
      endcase
      ctl_d = state_ctl(state_d, bus.opcode[2:0]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         ctl_q       <= '0;
         init_pend_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         ctl_q       <= ctl_d;
         init_pend_q <= init_pend_d;
      end
   end

   // Stack state is only known in the pop cycle itself, so squash there.
   always_comb begin
      ctl = ctl_q;
      if (uflow) begin
         ctl.cmd_w        = 1'b0;
         ctl.r1_w         = 1'b0;
         ctl.r2_w         = 1'b0;
         ctl.sr_w         = 1'b0;
         ctl.pc_w         = 1'b0;
         ctl.write_memory = 1'b0;
      end
   end

   assign bus.cmd_w        = ctl.cmd_w;
   assign bus.R1_w         = ctl.r1_w;
   assign bus.R2_w         = ctl.r2_w;
   assign bus.SR_w         = ctl.sr_w;
   assign bus.PC_w         = ctl.pc_w;
   assign bus.SR_inc       = ctl.sr_inc;
   assign bus.PC_inc       = ctl.pc_inc;
   assign bus.SR_incc      = ctl.sr_incc;
   assign bus.PC_incc      = ctl.pc_incc;
   assign bus.alu_func     = ctl.alu_func;
   assign bus.addr_sel     = ctl.addr_sel;
   assign bus.data_sel     = ctl.data_sel;
   assign bus.write_memory = ctl.write_memory;
   assign bus.error        = ctl.error;
   assign bus.halted       = ctl.halted;

endmodule
